led_pwm_fader: RTL

//  Multi-channel PWM LED brightness controller; successor to the single-LED fixed-intensity dimmer.
//  Per-channel run-time duty registers, a shared PWM period counter and glitch-free linear fade-in/fade-out.

---
 rtl/led_pwm_fader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/led_pwm_fader.sv
// led_pwm_fader
//   Multi-channel PWM LED brightness controller with per-channel run-time duty
//   registers, a shared PWM period counter and linear fade-in/fade-out. Each
//   channel's level only moves on a PWM period boundary, so a period is never
//   cut short or stretched by a fade step.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   data      per-channel on request (1 = lit at duty, 0 = dark)
//   duty_wr   single-cycle duty register write strobe
//   duty_ch   channel index for the duty write (out-of-range indices ignored)
//   duty_val  new target duty for duty_ch
//   led       registered PWM outputs
//   busy      1 while the channel is fading (RISE or FALL)
//
// Configuration
//   LED_GAMMA_EN  when defined, the comparator uses g = (level*level) >> WIDTH
//                 (squared-law curve), registered, adding one clk to led latency.
//                 Fade steps still act on the linear level.

module led_pwm_fader #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 12,
    parameter int PRESCALE  = 1,
    parameter int FADE_STEP = 64,
    parameter int DUTY_RST  = 96
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [CHANNELS-1:0]                                data,
    input  logic                                               duty_wr,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] duty_ch,
    input  logic [WIDTH-1:0]                                   duty_val,
    output logic [CHANNELS-1:0]                                led,
    output logic [CHANNELS-1:0]                                busy
);

    localparam int               PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH:0]   STEP1 = (WIDTH+1)'(FADE_STEP);

    typedef enum logic [1:0] {IDLE, RISE, HOLD, FALL} state_t;

    logic [PW-1:0]    pre;
    logic             tick;
    logic [WIDTH-1:0] cnt;
    logic             pb;

    logic [WIDTH-1:0] duty      [CHANNELS];
    logic [WIDTH-1:0] level     [CHANNELS];
    logic [WIDTH-1:0] level_nxt [CHANNELS];
    state_t           state     [CHANNELS];
    state_t           state_nxt [CHANNELS];

    logic [WIDTH-1:0] tgt    [CHANNELS];
    logic [WIDTH:0]   up     [CHANNELS];
    logic [WIDTH:0]   dn     [CHANNELS];
    logic [WIDTH-1:0] rise_l [CHANNELS];
    logic [WIDTH-1:0] fall_l [CHANNELS];

    assign tick = (pre == PW'(PRESCALE - 1));
    assign pb   = tick && (cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            cnt <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick)
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++)
                duty[i] <= WIDTH'(DUTY_RST);
        end else if (duty_wr && (32'(duty_ch) < CHANNELS)) begin
            duty[duty_ch] <= duty_val;
        end
    end

    // Step values are computed one bit wider and clamped to the target, so a
    // step can neither wrap past full scale nor underflow below zero.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            tgt[i]       = data[i] ? duty[i] : '0;
            up[i]        = {1'b0, level[i]} + STEP1;
            dn[i]        = ({1'b0, level[i]} >= STEP1) ? ({1'b0, level[i]} - STEP1) : '0;
            rise_l[i]    = (up[i] > {1'b0, tgt[i]}) ? tgt[i] : up[i][WIDTH-1:0];
            fall_l[i]    = (dn[i] < {1'b0, tgt[i]}) ? tgt[i] : dn[i][WIDTH-1:0];
            state_nxt[i] = state[i];
            level_nxt[i] = level[i];
            if (pb) begin
                if (state[i] == IDLE) begin
                    if (data[i] && (duty[i] != '0)) begin
                        state_nxt[i] = RISE;
                        level_nxt[i] = rise_l[i];
                    end
                end else if (tgt[i] > level[i]) begin
                    level_nxt[i] = rise_l[i];
                    state_nxt[i] = (rise_l[i] == tgt[i]) ? HOLD : RISE;
                end else if (tgt[i] < level[i]) begin
                    level_nxt[i] = fall_l[i];
                    if (fall_l[i] != tgt[i])
                        state_nxt[i] = FALL;
                    else
                        state_nxt[i] = (tgt[i] == '0) ? IDLE : HOLD;
                end else begin
                    state_nxt[i] = (tgt[i] == '0) ? IDLE : HOLD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state[i] <= IDLE;
                level[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state[i] <= state_nxt[i];
                level[i] <= level_nxt[i];
                busy[i]  <= (state_nxt[i] == RISE) || (state_nxt[i] == FALL);
            end
        end
    end

`ifdef LED_GAMMA_EN
    logic [2*WIDTH-1:0] sq [CHANNELS];
    logic [WIDTH-1:0]   g  [CHANNELS];
    logic [WIDTH-1:0]   cnt_d;

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++)
            sq[i] = {{WIDTH{1'b0}}, level[i]} * {{WIDTH{1'b0}}, level[i]};
    end

    // cnt is delayed alongside g so each period still sweeps cnt 0..max
    // against a single g value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++)
                g[i] <= '0;
            cnt_d <= '0;
            led   <= '0;
        end else begin
            cnt_d <= cnt;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                g[i]   <= WIDTH'(sq[i] >> WIDTH);
                led[i] <= (g[i] > cnt_d);
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++)
                led[i] <= (level[i] > cnt);
        end
    end
`endif

endmodule
